// File: rtl/lsm_engine_if.sv
// Signal bundle for lsm_engine: operation control, register-file access and
// the req/ack memory handshake. The engine side uses the master modport.
interface lsm_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
);
    logic              start;
    logic              is_store;
    logic              descend;
    logic [NREG-1:0]   reg_mask;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic [REG_AW:0]   xfer_count;
    logic [REG_AW-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_wen;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  start, is_store, descend, reg_mask, base_addr,
        input  rf_rdata, mem_rdata, mem_ack,
        output busy, done, xfer_count,
        output rf_raddr, rf_waddr, rf_wdata, rf_wen,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output start, is_store, descend, reg_mask, base_addr,
        output rf_rdata, mem_rdata, mem_ack,
        input  busy, done, xfer_count,
        input  rf_raddr, rf_waddr, rf_wdata, rf_wen,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsm_engine.sv
// Load/store-multiple sequencer: walks a register mask, performing one
// memory transfer per set bit in ascending or descending register order.
module lsm_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic         clk,
    input  logic         reset,
    lsm_engine_if.master bus
);

    localparam int CNT_W = REG_AW + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        MEM  = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [NREG-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              store_q, store_d;
    logic              desc_q, desc_d;
    logic [REG_AW-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [REG_AW-1:0] pick;
    logic              in_mem;

    // Select lowest (ascending) or highest (descending) set bit of the remaining mask.
    always_comb begin
        pick = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (desc_q) begin
                if (mask_q[i]) pick = REG_AW'(i);
            end else begin
                if (mask_q[NREG-1-i]) pick = REG_AW'(NREG-1-i);
            end
        end
    end

    // Next-state logic: sequencing, mask retirement, address stepping, counting.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        store_d = store_q;
        desc_d  = desc_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mask_d  = bus.reg_mask;
                    addr_d  = bus.base_addr;
                    store_d = bus.is_store;
                    desc_d  = bus.descend;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (mask_q == '0) begin
                    state_d = DONE;
                end else begin
                    cur_d   = pick;
                    state_d = MEM;
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    mask_d = mask_q & ~(NREG'(1) << cur_q);
                    addr_d = desc_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (store_q) begin
                        state_d = SCAN;
                    end else begin
                        cap_d   = bus.mem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB:      state_d = SCAN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state; reset clears state so mem_req/rf_wen drop asynchronously.
    always_comb begin
        in_mem         = (state_q == MEM);
        bus.busy       = (state_q != IDLE);
        bus.done       = (state_q == DONE);
        bus.mem_req    = in_mem;
        bus.mem_we     = in_mem && store_q;
        bus.mem_addr   = in_mem ? addr_q : '0;
        bus.mem_wdata  = in_mem ? bus.rf_rdata : '0;
        bus.rf_raddr   = cur_q;
        bus.rf_waddr   = cur_q;
        bus.rf_wdata   = cap_q;
        bus.rf_wen     = (state_q == WB);
        bus.xfer_count = cnt_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            store_q <= 1'b0;
            desc_q  <= 1'b0;
            cur_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            desc_q  <= desc_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

endmodule

// File: tb/tb_lsm_engine.sv
// Self-checking bench for lsm_engine: a transfer-list model built from the
// mask, direction and base address, checked against the DUT every cycle.
module tb_lsm_engine;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [2:0]  rg;
        logic [15:0] wdata;
    } req_t;

    typedef struct {
        logic [2:0]  rg;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    lsm_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .REG_AW(REG_AW)) bus ();

    lsm_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .REG_AW(REG_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit active = 1'b0;
    int start_cyc = 0;
    int exp_done = 0;
    int exp_n = 0;
    int last_count = 0;
    int wait_cyc = 0;
    int wcnt = 0;
    int req_cycles = 0;
    int done_lat = -1;

    req_t        exp_req[$];
    wr_t         exp_wr[$];
    logic [15:0] resp_q[$];
    logic [15:0] fixed_rd[$];
    logic [15:0] act_addr[$];
    wr_t         act_wr[$];
    logic [15:0] model_rf[8];
    logic [15:0] saved_rf[8];
    logic [15:0] tb_rf[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Register file: mirror of DUT writes, combinational read.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) tb_rf[i] <= model_rf[i];
        end else if (bus.rf_wen) begin
            tb_rf[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    always_comb bus.rf_rdata = tb_rf[bus.rf_raddr];

    // Memory responder: acks after wait_cyc stall cycles, supplies load data.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            wcnt = 0;
        end else if (bus.mem_req && !bus.mem_ack) begin
            if (wcnt == wait_cyc) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = (resp_q.size() != 0) ? resp_q.pop_front() : 16'($urandom);
                wcnt = 0;
            end else begin
                bus.mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_mem_req", 32'(bus.mem_req), 0);
            chk("rst_rf_wen", 32'(bus.rf_wen), 0);
            chk("rst_busy", 32'(bus.busy), 0);
        end else begin
            chk("busy", 32'(bus.busy), 32'(active && cyc >= start_cyc && cyc <= exp_done));
            chk("done", 32'(bus.done), 32'(active && cyc == exp_done));
            if (active && cyc == start_cyc) chk("cnt_clear", 32'(bus.xfer_count), 0);
            if (!active) chk("idle_count", 32'(bus.xfer_count), 32'(last_count));
            if (bus.mem_req) begin
                req_cycles++;
                if (exp_req.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_unexpected: got mem_req=1 addr=0x%0h expected no request", bus.mem_addr);
                end else begin
                    chk("mem_we", 32'(bus.mem_we), 32'(exp_req[0].we));
                    chk("mem_addr", 32'(bus.mem_addr), 32'(exp_req[0].addr));
                    chk("rf_raddr", 32'(bus.rf_raddr), 32'(exp_req[0].rg));
                    if (exp_req[0].we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_req[0].wdata));
                    if (bus.mem_ack) begin
                        act_addr.push_back(bus.mem_addr);
                        void'(exp_req.pop_front());
                    end
                end
            end
            if (bus.rf_wen) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected: got rf_wen=1 reg=%0d expected no write", bus.rf_waddr);
                end else begin
                    wr_t w;
                    w.rg = bus.rf_waddr;
                    w.data = bus.rf_wdata;
                    chk("rf_waddr", 32'(bus.rf_waddr), 32'(exp_wr[0].rg));
                    chk("rf_wdata", 32'(bus.rf_wdata), 32'(exp_wr[0].data));
                    act_wr.push_back(w);
                    void'(exp_wr.pop_front());
                end
            end
            if (bus.done) begin
                chk("final_count", 32'(bus.xfer_count), 32'(exp_n));
                chk("req_left", 32'(exp_req.size()), 0);
                chk("wr_left", 32'(exp_wr.size()), 0);
                done_lat = cyc - start_cyc + 1;
                if (active) begin
                    last_count = exp_n;
                    active = 1'b0;
                end
            end
        end
    end

    task automatic launch_op(input bit st, input bit ds, input logic [7:0] m,
                             input logic [15:0] base, input int w, input bit poke);
        logic [2:0] order[$];
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (ds) order.push_front(3'(i));
                else    order.push_back(3'(i));
            end
        end
        act_addr.delete();
        act_wr.delete();
        req_cycles = 0;
        done_lat = -1;
        foreach (order[j]) begin
            req_t r;
            wr_t  x;
            r.we    = st;
            r.addr  = ds ? base - 16'(j) : base + 16'(j);
            r.rg    = order[j];
            r.wdata = st ? model_rf[order[j]] : '0;
            exp_req.push_back(r);
            if (!st) begin
                x.rg   = order[j];
                x.data = (fixed_rd.size() != 0) ? fixed_rd.pop_front() : 16'($urandom);
                resp_q.push_back(x.data);
                exp_wr.push_back(x);
                model_rf[x.rg] = x.data;
            end
        end
        @(negedge clk);
        #2;
        wait_cyc      = w;
        bus.start     = 1'b1;
        bus.is_store  = st;
        bus.descend   = ds;
        bus.reg_mask  = m;
        bus.base_addr = base;
        start_cyc     = cyc + 1;
        exp_n         = order.size();
        exp_done      = start_cyc + exp_n * (w + 2 + (st ? 0 : 1)) + 1;
        active        = 1'b1;
        @(negedge clk);
        #2;
        bus.start     = 1'b0;
        bus.is_store  = ~st;
        bus.descend   = ~ds;
        bus.reg_mask  = 8'($urandom);
        bus.base_addr = 16'($urandom);
        if (poke) begin
            repeat (4) @(negedge clk);
            #2;
            bus.start = 1'b1;
            @(negedge clk);
            #2;
            bus.start = 1'b0;
        end
    endtask

    task automatic wait_op(input string name);
        int t = 0;
        while (active && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (active) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, t);
            active = 1'b0;
            exp_req.delete();
            exp_wr.delete();
            resp_q.delete();
        end
        @(negedge clk);
        #2;
    endtask

    task automatic run_op(input string name, input bit st, input bit ds, input logic [7:0] m,
                          input logic [15:0] base, input int w, input bit poke);
        launch_op(st, ds, m, base, w, poke);
        wait_op(name);
    endtask

    logic [15:0] wrap_addrs[8];

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.is_store = 1'b0;
        bus.descend = 1'b0;
        bus.reg_mask = '0;
        bus.base_addr = '0;
        for (int i = 0; i < 8; i++) model_rf[i] = 16'($urandom);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_mem_we", 32'(bus.mem_we), 0);
        chk("reset_xfer_count", 32'(bus.xfer_count), 0);
        chk("reset_rf_raddr", 32'(bus.rf_raddr), 0);
        chk("reset_rf_waddr", 32'(bus.rf_waddr), 0);
        chk("reset_rf_wdata", 32'(bus.rf_wdata), 0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 0);
        chk("reset_mem_wdata", 32'(bus.mem_wdata), 0);
        #2 reset = 1'b1;
        @(negedge clk);
        #2;

        // Store R0,R2 ascending from 0x0040, zero-wait memory.
        run_op("t1", 1'b1, 1'b0, 8'b0000_0101, 16'h0040, 0, 1'b0);
        chk("t1_latency", 32'(done_lat), 6);
        chk("t1_addr0", 32'(act_addr[0]), 32'h0040);
        chk("t1_addr1", 32'(act_addr[1]), 32'h0041);
        chk("t1_count", 32'(bus.xfer_count), 2);

        // Load R7 then R1 descending from 0x0100.
        fixed_rd.push_back(16'hA5A5);
        fixed_rd.push_back(16'h5A5A);
        run_op("t2", 1'b0, 1'b1, 8'b1000_0010, 16'h0100, 0, 1'b0);
        chk("t2_wr0_reg", 32'(act_wr[0].rg), 7);
        chk("t2_wr0_data", 32'(act_wr[0].data), 32'hA5A5);
        chk("t2_wr1_reg", 32'(act_wr[1].rg), 1);
        chk("t2_wr1_data", 32'(act_wr[1].data), 32'h5A5A);
        chk("t2_addr0", 32'(act_addr[0]), 32'h0100);
        chk("t2_addr1", 32'(act_addr[1]), 32'h00FF);

        // Single store with three wait states.
        run_op("t3", 1'b1, 1'b0, 8'h01, 16'h1230, 3, 1'b0);
        chk("t3_req_cycles", 32'(req_cycles), 4);
        chk("t3_writes", 32'(act_addr.size()), 1);
        chk("t3_latency", 32'(done_lat), 7);

        // Empty mask.
        run_op("t4", 1'b1, 1'b0, 8'h00, 16'h2000, 0, 1'b0);
        chk("t4_latency", 32'(done_lat), 2);
        chk("t4_no_req", 32'(req_cycles), 0);
        chk("t4_count", 32'(bus.xfer_count), 0);

        // Full-mask load across the address wrap, with a stray start mid-run.
        run_op("t5", 1'b0, 1'b0, 8'hFF, 16'hFFFE, 0, 1'b1);
        wrap_addrs = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        chk("t5_n", 32'(act_addr.size()), 8);
        for (int i = 0; i < 8; i++) chk("t5_addr", 32'(act_addr[i]), 32'(wrap_addrs[i]));
        chk("t5_count", 32'(bus.xfer_count), 8);

        // Reset during MEM of a load aborts the operation.
        saved_rf = model_rf;
        launch_op(1'b0, 1'b0, 8'b0011_0100, 16'h0300, 2, 1'b0);
        begin
            int t = 0;
            while (!bus.mem_req && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("t6_reached_mem", 32'(bus.mem_req), 1);
        end
        #2 reset = 1'b0;
        #1;
        chk("t6_abort_req", 32'(bus.mem_req), 0);
        chk("t6_abort_busy", 32'(bus.busy), 0);
        chk("t6_abort_wen", 32'(bus.rf_wen), 0);
        active = 1'b0;
        last_count = 0;
        exp_req.delete();
        exp_wr.delete();
        resp_q.delete();
        model_rf = saved_rf;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2;
        run_op("t6_after", 1'b0, 1'b0, 8'b0011_0100, 16'h0300, 0, 1'b0);
        chk("t6_after_count", 32'(bus.xfer_count), 3);

        // Randomized operations.
        for (int k = 0; k < 30; k++) begin
            run_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                   16'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
